alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_pkg.sv | 33 +++
 rtl/alu_exec_decoder.sv | 75 +++++++
 rtl/alu_exec_unit.sv | 147 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg
// Shared definitions for the accumulator CPU execute slice:
//   - opcode_e     : the eight instruction opcodes, WAIT through NOP
//   - RE_*         : bit positions inside the reg_en source-select vector
//   - *_DEF / *_W  : default datapath, opcode and register-address widths
// Build option: none here. ALU_SAT_EN is consumed by alu_exec_unit.
package alu_exec_pkg;

   localparam int BUS_W_DEF      = 8;
   localparam int OPCODE_W       = 3;
   localparam int REG_ADDR_W_DEF = 2;

   // Each reg_en bit enables one ALU source. sw and data_a go to the X
   // operand; imm, data_b and the result feedback go to the Y operand.
   localparam int REG_EN_W   = 5;
   localparam int RE_SW      = 0;
   localparam int RE_DATA_A  = 1;
   localparam int RE_IMM     = 2;
   localparam int RE_DATA_B  = 3;
   localparam int RE_RESULT  = 4;

   typedef enum logic [OPCODE_W-1:0] {
      OP_WAIT = 3'b000,
      OP_LDI  = 3'b001,
      OP_INSW = 3'b010,
      OP_MOV  = 3'b011,
      OP_ADD  = 3'b100,
      OP_ADDI = 3'b101,
      OP_ACC  = 3'b110,
      OP_NOP  = 3'b111
   } opcode_e;

endpackage

// File: rtl/alu_exec_decoder.sv
// alu_exec_decoder
// Purely combinational map from the instruction opcode to the execute-stage
// control signals.
// Ports:
//   opcode  in  instruction opcode field
//   add     out ALU adds X+Y instead of OR-ing them
//   pc_wait out instruction may stall the program counter
//   load    out ALU result register is updated
//   wr_res  out register-file write request (delayed by the top)
//   reg_en  out ALU source enables, bit map in alu_exec_pkg
module alu_exec_decoder
   import alu_exec_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output logic                add,
   output logic                pc_wait,
   output logic                load,
   output logic                wr_res,
   output logic [REG_EN_W-1:0] reg_en
);

   // Every output starts at 0 so WAIT and NOP only have to raise what they
   // need. Every opcode that loads the result register also writes it back.
   always_comb begin
      add     = 1'b0;
      pc_wait = 1'b0;
      load    = 1'b0;
      wr_res  = 1'b0;
      reg_en  = '0;
      case (opcode_e'(opcode))
         OP_WAIT: begin
            pc_wait = 1'b1;
         end
         OP_LDI: begin
            load           = 1'b1;
            wr_res         = 1'b1;
            reg_en[RE_IMM] = 1'b1;
         end
         OP_INSW: begin
            load          = 1'b1;
            wr_res        = 1'b1;
            reg_en[RE_SW] = 1'b1;
         end
         OP_MOV: begin
            load              = 1'b1;
            wr_res            = 1'b1;
            reg_en[RE_DATA_A] = 1'b1;
         end
         OP_ADD: begin
            add               = 1'b1;
            load              = 1'b1;
            wr_res            = 1'b1;
            reg_en[RE_DATA_A] = 1'b1;
            reg_en[RE_DATA_B] = 1'b1;
         end
         OP_ADDI: begin
            add               = 1'b1;
            load              = 1'b1;
            wr_res            = 1'b1;
            reg_en[RE_DATA_A] = 1'b1;
            reg_en[RE_IMM]    = 1'b1;
         end
         OP_ACC: begin
            add               = 1'b1;
            load              = 1'b1;
            wr_res            = 1'b1;
            reg_en[RE_DATA_A] = 1'b1;
            reg_en[RE_RESULT] = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Execute-stage slice of the accumulator CPU: opcode decode, the PC
// wait/stall condition, and a one-stage control pipeline that feeds a
// registered ALU.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   opcode         instruction opcode
//   cond_sel       wait source select: 1 = pattern_match, 0 = ready_in
//   cond_inv       inverts the wait condition
//   ready_in       external ready level
//   pattern_match  ready rising-edge pulse
//   imm            instruction immediate
//   wr_addr_in     destination register address from the instruction
//   sw             switch value, present in the execute (ALU) cycle
//   data_a, data_b register-file read data, present in the execute cycle
//   pc_en          program-counter advance enable (combinational)
//   wr_en          register-file write enable, aligned with result
//   wr_addr_out    register-file write address, aligned with result
//   result         registered ALU result
// Build option: define ALU_SAT_EN to make additions saturate at all ones
// instead of wrapping.
module alu_exec_unit
   import alu_exec_pkg::*;
#(
   parameter int BUS_WIDTH      = BUS_W_DEF,
   parameter int OPCODE_WIDTH   = OPCODE_W,
   parameter int REG_ADDR_WIDTH = REG_ADDR_W_DEF
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [OPCODE_WIDTH-1:0]   opcode,
   input  logic                      cond_sel,
   input  logic                      cond_inv,
   input  logic                      ready_in,
   input  logic                      pattern_match,
   input  logic [BUS_WIDTH-1:0]      imm,
   input  logic [REG_ADDR_WIDTH-1:0] wr_addr_in,
   input  logic [BUS_WIDTH-1:0]      sw,
   input  logic [BUS_WIDTH-1:0]      data_a,
   input  logic [BUS_WIDTH-1:0]      data_b,
   output logic                      pc_en,
   output logic                      wr_en,
   output logic [REG_ADDR_WIDTH-1:0] wr_addr_out,
   output logic [BUS_WIDTH-1:0]      result
);

   logic                      dec_add;
   logic                      dec_pc_wait;
   logic                      dec_load;
   logic                      dec_wr_res;
   logic [REG_EN_W-1:0]       dec_reg_en;

   logic [BUS_WIDTH-1:0]      s1_imm;
   logic                      s1_load;
   logic                      s1_add;
   logic [REG_EN_W-1:0]       s1_reg_en;

   logic                      wr_en_q1;
   logic [REG_ADDR_WIDTH-1:0] wr_addr_q1;

   logic                      wait_cond;
   logic [BUS_WIDTH-1:0]      alu_x;
   logic [BUS_WIDTH-1:0]      alu_y;
   logic [BUS_WIDTH-1:0]      alu_next;
`ifdef ALU_SAT_EN
   logic [BUS_WIDTH:0]        alu_sum;
`else
   logic [BUS_WIDTH-1:0]      alu_sum;
`endif

   alu_exec_decoder u_decoder (
      .opcode  (opcode),
      .add     (dec_add),
      .pc_wait (dec_pc_wait),
      .load    (dec_load),
      .wr_res  (dec_wr_res),
      .reg_en  (dec_reg_en)
   );

   // The PC stalls only on a WAIT whose selected condition, after the
   // optional inversion, is true. This path has no registers, so pc_en
   // follows its inputs even while reset is asserted.
   always_comb begin
      wait_cond = cond_sel ? pattern_match : ready_in;
      pc_en     = ~(dec_pc_wait & (wait_cond ^ cond_inv));
   end

   // The ALU uses the controls registered in stage 1 and the operands
   // that arrive in the same execute cycle. The result feedback is the
   // register output itself, so back-to-back ACC instructions chain with
   // no bubble. A disabled source contributes zero to its OR.
   always_comb begin
      alu_x = '0;
      alu_y = '0;
      if (s1_reg_en[RE_SW])     alu_x = alu_x | sw;
      if (s1_reg_en[RE_DATA_A]) alu_x = alu_x | data_a;
      if (s1_reg_en[RE_IMM])    alu_y = alu_y | s1_imm;
      if (s1_reg_en[RE_DATA_B]) alu_y = alu_y | data_b;
      if (s1_reg_en[RE_RESULT]) alu_y = alu_y | result;
`ifdef ALU_SAT_EN
      alu_sum = {1'b0, alu_x} + {1'b0, alu_y};
      if (s1_add) begin
         alu_next = alu_sum[BUS_WIDTH] ? '1 : alu_sum[BUS_WIDTH-1:0];
      end else begin
         alu_next = alu_x | alu_y;
      end
`else
      alu_sum = alu_x + alu_y;
      if (s1_add) begin
         alu_next = alu_sum;
      end else begin
         alu_next = alu_x | alu_y;
      end
`endif
   end

   // Stage 1 captures the decoded controls and the immediate. The write
   // strobe and address travel through two stages so they line up with
   // the result they describe. Reset clears every stage, which discards
   // any instruction that is in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_imm      <= '0;
         s1_load     <= 1'b0;
         s1_add      <= 1'b0;
         s1_reg_en   <= '0;
         wr_en_q1    <= 1'b0;
         wr_addr_q1  <= '0;
         wr_en       <= 1'b0;
         wr_addr_out <= '0;
         result      <= '0;
      end else begin
         s1_imm      <= imm;
         s1_load     <= dec_load;
         s1_add      <= dec_add;
         s1_reg_en   <= dec_reg_en;
         wr_en_q1    <= dec_wr_res;
         wr_addr_q1  <= wr_addr_in;
         wr_en       <= wr_en_q1;
         wr_addr_out <= wr_addr_q1;
         if (s1_load) begin
            result <= alu_next;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit: hand-written reset, latency,
// accumulate, hold and mid-pipeline reset sequences around a table of
// single-instruction vectors with hand-computed results.
// Build option: ALU_SAT_EN changes the expected results of overflowing adds.
module tb_alu_exec_unit;
   import alu_exec_pkg::*;

   logic       clk;
   logic       reset;
   logic [2:0] opcode;
   logic       cond_sel;
   logic       cond_inv;
   logic       ready_in;
   logic       pattern_match;
   logic [7:0] imm;
   logic [1:0] wr_addr_in;
   logic [7:0] sw;
   logic [7:0] data_a;
   logic [7:0] data_b;
   logic       pc_en;
   logic       wr_en;
   logic [1:0] wr_addr_out;
   logic [7:0] result;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic [2:0] op;
      logic [7:0] imm;
      logic [1:0] addr;
      logic [7:0] sw;
      logic [7:0] a;
      logic [7:0] b;
      logic       csel;
      logic       cinv;
      logic       rdy;
      logic       pm;
      logic       exp_pc;
      logic [7:0] exp_res;
      logic       exp_wr;
   } vec_t;

   vec_t vecs[16];

   alu_exec_unit dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .cond_sel      (cond_sel),
      .cond_inv      (cond_inv),
      .ready_in      (ready_in),
      .pattern_match (pattern_match),
      .imm           (imm),
      .wr_addr_in    (wr_addr_in),
      .sw            (sw),
      .data_a        (data_a),
      .data_b        (data_b),
      .pc_en         (pc_en),
      .wr_en         (wr_en),
      .wr_addr_out   (wr_addr_out),
      .result        (result)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
      end
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Issue one instruction, check pc_en while it decodes, follow it with
   // a NOP and check the result and write strobe two edges after issue.
   task automatic applyStimulus(input vec_t v, input int idx);
      opcode        = v.op;
      imm           = v.imm;
      wr_addr_in    = v.addr;
      sw            = v.sw;
      data_a        = v.a;
      data_b        = v.b;
      cond_sel      = v.csel;
      cond_inv      = v.cinv;
      ready_in      = v.rdy;
      pattern_match = v.pm;
      #1;
      checkOutput($sformatf("vec%0d pc_en", idx), {7'b0, pc_en}, {7'b0, v.exp_pc});
      stepClock();
      opcode = OP_NOP;
      stepClock();
      checkOutput($sformatf("vec%0d result", idx), result, v.exp_res);
      checkOutput($sformatf("vec%0d wr_en", idx), {7'b0, wr_en}, {7'b0, v.exp_wr});
      checkOutput($sformatf("vec%0d wr_addr", idx), {6'b0, wr_addr_out}, {6'b0, v.addr});
   endtask

   initial begin
      logic [7:0] add_ovf_res;
      logic [7:0] add_wrap_res;
      logic [7:0] acc_exp[4];

      tests_run    = 0;
      tests_failed = 0;

`ifdef ALU_SAT_EN
      add_ovf_res  = 8'hFF;
      add_wrap_res = 8'hFF;
`else
      add_ovf_res  = 8'h10;
      add_wrap_res = 8'h00;
`endif

      //           op       imm    ad  sw     a      b      cs    ci    rdy   pm    pc    res          wr
      vecs[0]  = '{OP_LDI,  8'hC3, 1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3,       1'b1};
      vecs[1]  = '{OP_INSW, 8'h00, 2, 8'hA5, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5,       1'b1};
      vecs[2]  = '{OP_MOV,  8'h81, 3, 8'h40, 8'h3C, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C,       1'b1};
      vecs[3]  = '{OP_ADD,  8'h00, 0, 8'h00, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, add_ovf_res, 1'b1};
      vecs[4]  = '{OP_ADDI, 8'h04, 1, 8'h80, 8'h03, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07,       1'b1};
      vecs[5]  = '{OP_ADD,  8'h00, 2, 8'h00, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, add_wrap_res,1'b1};
      vecs[6]  = '{OP_ADD,  8'h00, 3, 8'h00, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h46,       1'b1};
      vecs[7]  = '{OP_WAIT, 8'h11, 0, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h46,       1'b0};
      vecs[8]  = '{OP_WAIT, 8'h11, 1, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h46,       1'b0};
      vecs[9]  = '{OP_WAIT, 8'h11, 2, 8'h00, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h46,       1'b0};
      vecs[10] = '{OP_WAIT, 8'h11, 3, 8'h00, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h46,       1'b0};
      vecs[11] = '{OP_WAIT, 8'h11, 0, 8'h00, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h46,       1'b0};
      vecs[12] = '{OP_WAIT, 8'h11, 1, 8'h00, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h46,       1'b0};
      vecs[13] = '{OP_NOP,  8'h22, 2, 8'h55, 8'h55, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h46,       1'b0};
      vecs[14] = '{OP_ADDI, 8'hFF, 2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF,       1'b1};
      vecs[15] = '{OP_LDI,  8'h00, 3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00,       1'b1};

      acc_exp[0] = 8'h01;
      acc_exp[1] = 8'h03;
      acc_exp[2] = 8'h05;
      acc_exp[3] = 8'h07;

      // Reset for two edges while a stalling WAIT is presented.
      reset         = 1'b1;
      opcode        = OP_WAIT;
      cond_sel      = 1'b0;
      cond_inv      = 1'b0;
      ready_in      = 1'b1;
      pattern_match = 1'b0;
      imm           = 8'h00;
      wr_addr_in    = 2'd0;
      sw            = 8'h00;
      data_a        = 8'h00;
      data_b        = 8'h00;
      stepClock();
      stepClock();
      checkOutput("reset result", result, 8'h00);
      checkOutput("reset wr_en", {7'b0, wr_en}, 8'h00);
      checkOutput("reset wr_addr", {6'b0, wr_addr_out}, 8'h00);
      checkOutput("reset pc_en comb", {7'b0, pc_en}, 8'h00);

      // First LDI after reset: result appears two edges after issue.
      reset      = 1'b0;
      opcode     = OP_LDI;
      imm        = 8'h5A;
      wr_addr_in = 2'd2;
      ready_in   = 1'b0;
      #1;
      checkOutput("ldi pc_en", {7'b0, pc_en}, 8'h01);
      stepClock();
      opcode = OP_NOP;
      checkOutput("ldi lat1 result", result, 8'h00);
      checkOutput("ldi lat1 wr_en", {7'b0, wr_en}, 8'h00);
      stepClock();
      checkOutput("ldi result", result, 8'h5A);
      checkOutput("ldi wr_en", {7'b0, wr_en}, 8'h01);
      checkOutput("ldi wr_addr", {6'b0, wr_addr_out}, 8'h02);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i], i);
      end

      // pattern_match pulse stalls the PC for that cycle only.
      opcode        = OP_WAIT;
      cond_sel      = 1'b1;
      cond_inv      = 1'b0;
      ready_in      = 1'b1;
      pattern_match = 1'b1;
      #1;
      checkOutput("pm pulse pc_en", {7'b0, pc_en}, 8'h00);
      stepClock();
      pattern_match = 1'b0;
      #1;
      checkOutput("pm after pc_en", {7'b0, pc_en}, 8'h01);
      cond_sel = 1'b0;
      ready_in = 1'b0;

      // LDI 1 then three back-to-back ACC with data_a = 2.
      opcode     = OP_LDI;
      imm        = 8'h01;
      wr_addr_in = 2'd1;
      data_a     = 8'h02;
      stepClock();
      opcode = OP_ACC;
      for (int k = 0; k < 4; k++) begin
         stepClock();
         checkOutput($sformatf("acc step%0d result", k), result, acc_exp[k]);
         checkOutput($sformatf("acc step%0d wr_en", k), {7'b0, wr_en}, 8'h01);
         if (k == 2) opcode = OP_NOP;
      end

      // LDI 0x33 followed by WAIT and NOP: result holds, no writes.
      opcode     = OP_LDI;
      imm        = 8'h33;
      wr_addr_in = 2'd3;
      stepClock();
      opcode = OP_WAIT;
      stepClock();
      checkOutput("hold ldi result", result, 8'h33);
      checkOutput("hold ldi wr_en", {7'b0, wr_en}, 8'h01);
      opcode = OP_NOP;
      stepClock();
      checkOutput("hold wait result", result, 8'h33);
      checkOutput("hold wait wr_en", {7'b0, wr_en}, 8'h00);
      stepClock();
      checkOutput("hold nop result", result, 8'h33);
      checkOutput("hold nop wr_en", {7'b0, wr_en}, 8'h00);

      // Reset while an LDI sits in stage 1 and an ADD is being issued.
      opcode     = OP_LDI;
      imm        = 8'h77;
      wr_addr_in = 2'd1;
      stepClock();
      reset  = 1'b1;
      opcode = OP_ADD;
      data_a = 8'h01;
      data_b = 8'h01;
      stepClock();
      checkOutput("midrst result", result, 8'h00);
      checkOutput("midrst wr_en", {7'b0, wr_en}, 8'h00);
      checkOutput("midrst wr_addr", {6'b0, wr_addr_out}, 8'h00);
      reset  = 1'b0;
      opcode = OP_NOP;
      stepClock();
      checkOutput("postrst result", result, 8'h00);
      checkOutput("postrst wr_en", {7'b0, wr_en}, 8'h00);
      stepClock();
      checkOutput("postrst2 result", result, 8'h00);
      checkOutput("postrst2 wr_en", {7'b0, wr_en}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
